// File: rtl/ibr128_ctr_seq.sv
// Counter-block sequencer for IBR128 CTR mode: feeds (IV, index) to an external
// ripple-carry pipelined adder and hands each settled sum to the cipher core.
module ibr128_ctr_seq #(
  parameter int LAT   = 4,
  parameter int IDX_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [63:0]      Iv,
  input  logic [IDX_W-1:0] NumBlocks,
  output logic [63:0]      AddA,
  output logic [63:0]      AddB,
  output logic             AddEn,
  input  logic [63:0]      AddS,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [63:0]      OutCtr,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_FIN     = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] remaining;
  logic [CW-1:0]    settle_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      AddA       <= '0;
      idx        <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            AddA       <= Iv;
            idx        <= '0;
            remaining  <= NumBlocks;
            settle_cnt <= '0;
            state      <= (NumBlocks != '0) ? S_SETTLE : S_FIN;
          end
        end
        // Operands stay frozen while the adder ripples carries across its stages
        S_SETTLE: begin
          if (settle_cnt == CW'(LAT - 1)) begin
            settle_cnt <= '0;
            state      <= S_PRESENT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_PRESENT: begin
          if (OutReady) begin
            remaining <= remaining - 1'b1;
            if (remaining == IDX_W'(1)) begin
              state <= S_FIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SETTLE;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // AddEn low in PRESENT freezes the adder, which keeps OutCtr bit-stable during stalls
  assign AddB     = 64'(idx);
  assign AddEn    = (state == S_SETTLE);
  assign OutValid = (state == S_PRESENT);
  assign OutCtr   = OutValid ? AddS : 64'd0;
  assign Busy     = (state != S_IDLE);
  assign Done     = (state == S_FIN);

endmodule

// File: tb/tb_ibr128_ctr_seq.sv
// Bench for ibr128_ctr_seq: models the 4-stage 16-bit ripple adder and checks
// per-cycle output vectors plus a mid-run reset sequence.
module tb_ibr128_ctr_seq;

  logic        Clk, Rst, Start, OutReady;
  logic [63:0] Iv, AddA, AddB, AddS, OutCtr;
  logic [31:0] NumBlocks;
  logic        AddEn, OutValid, Busy, Done;

  int checks   = 0;
  int failures = 0;

  ibr128_ctr_seq #(.LAT(4), .IDX_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Iv(Iv), .NumBlocks(NumBlocks),
    .AddA(AddA), .AddB(AddB), .AddEn(AddEn), .AddS(AddS),
    .OutValid(OutValid), .OutReady(OutReady), .OutCtr(OutCtr),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Each stage adds its 16-bit slice plus the carry its neighbour produced last cycle
  logic [15:0] st_sum [4];
  logic        st_c   [4];
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < 4; k++) begin
        st_sum[k] <= '0;
        st_c[k]   <= 1'b0;
      end
    end else if (AddEn) begin
      for (int k = 0; k < 4; k++) begin
        {st_c[k], st_sum[k]} <= {1'b0, AddA[16*k +: 16]} + {1'b0, AddB[16*k +: 16]}
                                + ((k == 0) ? 17'd0 : {16'd0, st_c[(k == 0) ? 0 : k-1]});
      end
    end
  end
  assign AddS = {st_sum[3], st_sum[2], st_sum[1], st_sum[0]};

  typedef struct {
    logic        start;
    logic [63:0] iv;
    logic [31:0] num;
    logic        ready;
    logic        exp_valid;
    logic [63:0] exp_ctr;
    logic        exp_adden;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic vec(input logic s, input logic [63:0] iv, input logic [31:0] n, input logic r,
                     input logic v, input logic [63:0] c, input logic en, input logic b, input logic d);
    vec_t x;
    x.start = s; x.iv = iv; x.num = n; x.ready = r;
    x.exp_valid = v; x.exp_ctr = c; x.exp_adden = en; x.exp_busy = b; x.exp_done = d;
    vecs.push_back(x);
  endtask

  task automatic idle_v(input logic s, input logic [63:0] iv, input logic [31:0] n);
    vec(s, iv, n, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle_v(input int n);
    for (int i = 0; i < n; i++) vec(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic present_v(input logic r, input logic [63:0] c);
    vec(1'b0, 64'd0, 32'd0, r, 1'b1, c, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic fin_v(input logic s);
    vec(s, 64'h5555, 32'd7, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [63:0] iv, input logic [31:0] n, input logic r);
    Start = s; Iv = iv; NumBlocks = n; OutReady = r;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   cnt;

    // carry across the 16-bit stage boundary
    idle_v(1'b1, 64'h0000_0000_0000_FFFE, 32'd3);
    settle_v(4); present_v(1'b1, 64'h0000_0000_0000_FFFE);
    settle_v(4); present_v(1'b1, 64'h0000_0000_0000_FFFF);
    settle_v(4); present_v(1'b1, 64'h0000_0000_0001_0000);
    fin_v(1'b0); idle_v(1'b0, 64'd0, 32'd0);
    // full 64-bit wrap
    idle_v(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd2);
    settle_v(4); present_v(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    settle_v(4); present_v(1'b1, 64'h0000_0000_0000_0000);
    fin_v(1'b0); idle_v(1'b0, 64'd0, 32'd0);
    // backpressure for three cycles
    idle_v(1'b1, 64'h1234_5678_9ABC_DEF0, 32'd2);
    settle_v(4);
    present_v(1'b0, 64'h1234_5678_9ABC_DEF0);
    present_v(1'b0, 64'h1234_5678_9ABC_DEF0);
    present_v(1'b0, 64'h1234_5678_9ABC_DEF0);
    present_v(1'b1, 64'h1234_5678_9ABC_DEF0);
    settle_v(4); present_v(1'b1, 64'h1234_5678_9ABC_DEF1);
    fin_v(1'b0); idle_v(1'b0, 64'd0, 32'd0);
    // zero blocks
    idle_v(1'b1, 64'h0000_0000_0000_0042, 32'd0);
    fin_v(1'b0); idle_v(1'b0, 64'd0, 32'd0);
    // Start while busy is ignored
    idle_v(1'b1, 64'h0000_0000_0000_0100, 32'd2);
    settle_v(1);
    vec(1'b1, 64'hAAAA, 32'd5, 1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    settle_v(2);
    vec(1'b1, 64'hAAAA, 32'd5, 1'b1, 1'b1, 64'h100, 1'b0, 1'b1, 1'b0);
    settle_v(4); present_v(1'b1, 64'h101);
    fin_v(1'b1); idle_v(1'b0, 64'd0, 32'd0);

    Rst = 1'b1;
    apply_stimulus(1'b0, 64'd0, 32'd0, 1'b0);
    #1;
    check_output("reset AddEn", {63'd0, AddEn}, 64'd0);
    check_output("reset OutValid", {63'd0, OutValid}, 64'd0);
    check_output("reset Busy", {63'd0, Busy}, 64'd0);
    check_output("reset Done", {63'd0, Done}, 64'd0);
    check_output("reset AddA", AddA, 64'd0);
    check_output("reset AddB", AddB, 64'd0);
    step(); step();
    Rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply_stimulus(v.start, v.iv, v.num, v.ready);
      #1;
      check_output($sformatf("v%0d OutValid", i), {63'd0, OutValid}, {63'd0, v.exp_valid});
      check_output($sformatf("v%0d OutCtr", i), OutCtr, v.exp_ctr);
      check_output($sformatf("v%0d AddEn", i), {63'd0, AddEn}, {63'd0, v.exp_adden});
      check_output($sformatf("v%0d Busy", i), {63'd0, Busy}, {63'd0, v.exp_busy});
      check_output($sformatf("v%0d Done", i), {63'd0, Done}, {63'd0, v.exp_done});
      @(posedge Clk);
      #1;
    end

    // Reset during the second SETTLE of a four-block run
    apply_stimulus(1'b1, 64'h500, 32'd4, 1'b1);
    step();
    apply_stimulus(1'b0, 64'd0, 32'd0, 1'b1);
    check_output("midrst AddA", AddA, 64'h500);
    for (int i = 0; i < 5; i++) step();
    check_output("midrst AddB", AddB, 64'd1);
    check_output("midrst AddEn", {63'd0, AddEn}, 64'd1);
    #2;
    Rst = 1'b1;
    #1;
    check_output("async AddEn", {63'd0, AddEn}, 64'd0);
    check_output("async Busy", {63'd0, Busy}, 64'd0);
    check_output("async OutValid", {63'd0, OutValid}, 64'd0);
    check_output("async OutCtr", OutCtr, 64'd0);
    check_output("async AddA", AddA, 64'd0);
    check_output("async AddB", AddB, 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_output($sformatf("rst hold Done %0d", i), {63'd0, Done}, 64'd0);
    end
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_output($sformatf("post rst Done %0d", i), {63'd0, Done}, 64'd0);
    end

    apply_stimulus(1'b1, 64'h10, 32'd1, 1'b1);
    cnt = 0;
    do begin
      step();
      apply_stimulus(1'b0, 64'd0, 32'd0, 1'b1);
      cnt++;
    end while (!OutValid && cnt < 20);
    check_output("restart valid latency", 64'(cnt), 64'd5);
    check_output("restart OutCtr", OutCtr, 64'h10);
    step();
    check_output("restart Done", {63'd0, Done}, 64'd1);
    check_output("restart Busy fin", {63'd0, Busy}, 64'd1);
    step();
    check_output("restart Done end", {63'd0, Done}, 64'd0);
    check_output("restart Busy end", {63'd0, Busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
